// File: rtl/ftf_tx_scheduler_pkg.sv
// ftf_tx_scheduler_pkg: shared FTF link widths, codeword cardinality and payload range helper.
// The FNS header macros live here so every file of the slice sees one definition.
`ifndef FNS_VH
`define FNS_VH
`define FBLEN42 30
`define FTF42_CARD 30'd866988874
`define FTF_ID_W 2
`endif

package ftf_tx_scheduler_pkg;
    localparam int FBLEN = `FBLEN42;
    localparam int CODE_W = 42;
    // 2*F(43): count of 42-bit words free of 010/101 transitions
    localparam logic [FBLEN-1:0] FTF42_CARD = `FTF42_CARD;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [FBLEN-1:0] payload_t;

    function automatic logic ftf_legal(input payload_t d);
        return d < FTF42_CARD;
    endfunction
endpackage

// File: rtl/ftf_sync_fifo.sv
// ftf_sync_fifo: synchronous FIFO with occupancy count and async active-low reset.
module ftf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop & ~empty;
    // a full FIFO may still take a word when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rd_ptr];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    a_no_push_full: assert property (@(posedge clock) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: rtl/ftf_tx_scheduler.sv
// ftf_tx_scheduler: round-robin sharing of one external FTF_encoder_42 between requesters,
// with credit flow control since the encoder register cannot be stalled.
module ftf_tx_scheduler
    import ftf_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = `FTF_ID_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*FBLEN-1:0] req_data,
    output logic [FBLEN-1:0]         enc_datain,
    input  logic [CODE_W-1:0]        enc_codeout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CODE_W-1:0]        out_code,
    output logic [ID_W-1:0]          out_id,
    output logic                     err_range,
    input  logic                     err_clr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0] rr_ptr, winner, next_ptr, inflight_id;
    logic inflight_v, credit_ok, grant, legal;
    logic fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    payload_t payload;

    // an in-flight word has already claimed a FIFO slot
    assign credit_ok = !fifo_full && (int'(fifo_count) + int'(inflight_v) < FIFO_DEPTH);
    assign grant = rst_n & en & credit_ok & |req_valid;

    always_comb begin
        winner = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
    end

    assign next_ptr = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    assign payload = req_data[int'(winner)*FBLEN +: FBLEN];
    assign legal = ftf_legal(payload);
    assign req_ready = grant ? NUM_REQ'(1) << winner : '0;
    assign enc_datain = (grant && legal) ? payload : '0;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            inflight_v <= 1'b0;
            inflight_id <= '0;
            err_range <= 1'b0;
        end else begin
            if (grant) rr_ptr <= next_ptr;
            inflight_v <= grant & legal;
            inflight_id <= winner;
            err_range <= (grant & ~legal) | (err_range & ~err_clr);
        end
    end

    assign out_valid = ~fifo_empty;

    ftf_sync_fifo #(
        .WIDTH(ID_W + CODE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .rst_n(rst_n),
        .push (inflight_v),
        .pop  (out_valid & out_ready),
        .din  ({inflight_id, enc_codeout}),
        .dout ({out_id, out_code}),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_ftf_tx_scheduler.sv
// tb_ftf_tx_scheduler: directed checks of the scheduler with a registered stand-in encoder.
module tb_ftf_tx_scheduler;
    import ftf_tx_scheduler_pkg::*;

    logic clock = 1'b0;
    logic rst_n, en, out_ready, out_valid, err_range, err_clr;
    logic [3:0] req_valid, req_ready;
    logic [4*FBLEN-1:0] req_data;
    logic [FBLEN-1:0] enc_datain;
    logic [CODE_W-1:0] enc_codeout, out_code;
    logic [1:0] out_id;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    function automatic logic [CODE_W-1:0] enc_f(input logic [FBLEN-1:0] d);
        return {d[11:0], d} ^ 42'h2AAAAAAAAAA;
    endfunction

    always @(posedge clock) enc_codeout <= enc_f(enc_datain);

    ftf_tx_scheduler dut (
        .clock(clock), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .enc_datain(enc_datain), .enc_codeout(enc_codeout),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_id(out_id),
        .err_range(err_range), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int i, input logic [FBLEN-1:0] v);
        req_data[i*FBLEN +: FBLEN] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        err_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        err_clr = 1'b0;
        req_valid = 4'hF;
        req_data = '0;
        tick();
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (enc_datain !== '0) begin errors++; $display("FAIL reset_enc_datain: got %0d expected 0", enc_datain); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL reset_err_range: got %b expected 0", err_range); end
        req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        set_data(0, 30'd5);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        checks++; if (enc_datain !== 30'd5) begin errors++; $display("FAIL single_datain: got %0d expected 5", enc_datain); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_t2_valid: got %b expected 1", out_valid); end
        checks++; if (out_code !== enc_f(30'd5)) begin errors++; $display("FAIL single_code: got %h expected %h", out_code, enc_f(30'd5)); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", out_id); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_t3_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, FBLEN'(100 + i));
        for (int c = 0; c < 14; c++) begin
            logic [3:0] exp_rdy;
            req_valid = c < 12 ? 4'hF : 4'h0;
            exp_rdy = c < 12 ? 4'(1 << (c % 4)) : 4'h0;
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, req_ready, exp_rdy); end
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid c=%0d: got %b expected 1", c, out_valid); end
                checks++; if (out_id !== 2'((c - 2) % 4)) begin errors++; $display("FAIL rr_id c=%0d: got %0d expected %0d", c, out_id, (c - 2) % 4); end
                checks++; if (out_code !== enc_f(FBLEN'(100 + (c - 2) % 4))) begin errors++; $display("FAIL rr_code c=%0d: got %h expected %h", c, out_code, enc_f(FBLEN'(100 + (c - 2) % 4))); end
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000,
                                     4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
        do_reset();
        en = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, FBLEN'(200 + i));
        req_valid = 4'hF;
        for (int c = 0; c < 11; c++) begin
            out_ready = c >= 7;
            #1;
            checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
            if (c >= 5 && c <= 6) begin
                checks++; if (out_id !== 2'd0 || out_code !== enc_f(30'd200)) begin errors++; $display("FAIL bp_hold c=%0d: got id %0d code %h expected id 0 code %h", c, out_id, out_code, enc_f(30'd200)); end
            end
            if (c >= 7) begin
                checks++; if (out_valid !== 1'b1 || out_id !== 2'(c - 7)) begin errors++; $display("FAIL bp_out c=%0d: got valid %b id %0d expected valid 1 id %0d", c, out_valid, out_id, c - 7); end
                checks++; if (out_code !== enc_f(FBLEN'(200 + c - 7))) begin errors++; $display("FAIL bp_code c=%0d: got %h expected %h", c, out_code, enc_f(FBLEN'(200 + c - 7))); end
            end
            tick();
        end
        req_valid = '0;
        repeat (6) tick();
    endtask

    task automatic test_range_error();
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        set_data(2, FTF42_CARD);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rng_ready: got %b expected 0100", req_ready); end
        checks++; if (enc_datain !== '0) begin errors++; $display("FAIL rng_datain: got %0d expected 0", enc_datain); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL rng_err_set: got %b expected 1", err_range); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rng_dropped: got %b expected 0", out_valid); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL rng_err_clr: got %b expected 0", err_range); end
        set_data(2, FTF42_CARD - 1'b1);
        req_valid = 4'b0100;
        #1;
        checks++; if (enc_datain !== FTF42_CARD - 1'b1) begin errors++; $display("FAIL rng_max_datain: got %0d expected %0d", enc_datain, FTF42_CARD - 1'b1); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd2) begin errors++; $display("FAIL rng_max_out: got valid %b id %0d expected valid 1 id 2", out_valid, out_id); end
        checks++; if (out_code !== enc_f(FTF42_CARD - 1'b1)) begin errors++; $display("FAIL rng_max_code: got %h expected %h", out_code, enc_f(FTF42_CARD - 1'b1)); end
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL rng_max_err: got %b expected 0", err_range); end
        tick();
        set_data(2, FTF42_CARD);
        req_valid = 4'b0100;
        tick();
        err_clr = 1'b1;
        tick();
        req_valid = '0;
        err_clr = 1'b0;
        #1;
        checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL rng_set_wins: got %b expected 1", err_range); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL rng_clr_again: got %b expected 0", err_range); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        en = 1'b1;
        out_ready = 1'b0;
        set_data(1, 30'd11);
        set_data(3, 30'd33);
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== (c == 1 ? 4'b1000 : 4'b0010)) begin errors++; $display("FAIL mid_ready c=%0d: got %b", c, req_ready); end
            tick();
        end
        req_valid = 4'hF;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %b expected 1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        set_data(0, 30'd44);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_code !== enc_f(30'd44)) begin errors++; $display("FAIL mid_new_word: got valid %b id %0d code %h expected 1 0 %h", out_valid, out_id, out_code, enc_f(30'd44)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        set_data(2, 30'd777);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL en_grant: got %b expected 0100", req_ready); end
        tick();
        en = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready1: got %b expected 0000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready2: got %b expected 0000", req_ready); end
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_code !== enc_f(30'd777)) begin errors++; $display("FAIL en_drain: got valid %b id %0d code %h expected 1 2 %h", out_valid, out_id, out_code, enc_f(30'd777)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_empty: got %b expected 0", out_valid); end
        req_valid = '0;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_range_error();
        test_reset_midstream();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ftf_tx_scheduler.md
Name: ftf_tx_scheduler

Overview:
Shares one FTF_encoder_42 instance between NUM_REQ requesters, so several producers can drive one 42-bit crosstalk-avoidance-coded TSV link.
- Arbitration: round-robin, at most one grant per cycle.
- Encoder input: drives the encoder's datain.
- Encoder output: captures its registered codeout, tags each word with the requester id and queues it in a small FIFO.
- Downstream: presents words on a valid/ready interface.
- Flow control: credit-based, because the encoder register has no enable and cannot be stalled.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width; must equal clog2(NUM_REQ)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scheduler enable; low = no new grants, pipeline drains
req_valid  in  NUM_REQ  per-requester data valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data  in  NUM_REQ*`FBLEN42  packed binary payloads; requester i at [i*`FBLEN42 +: `FBLEN42]
enc_datain  out  `FBLEN42  to encoder datain
enc_codeout  in  42  from encoder codeout (1-cycle registered)
out_valid  out  1  coded word available
out_ready  in  1  downstream accept
out_code  out  42  FTF-coded word
out_id  out  ID_W  originating requester
err_range  out  1  sticky: an out-of-range payload was dropped
err_clr  in  1  clears err_range

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0, inflight_v=0, FIFO empty, err_range=0.
  - enc_datain=0, out_valid=0, req_ready=0.
- Credit: credit_ok = (fifo_count + inflight_v) < FIFO_DEPTH.
- Grant condition: en & credit_ok & |req_valid.
  - Winner is the first valid requester at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in that cycle; all other req_ready bits are 0.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Legal payload (req_data of winner < `FTF42_CARD):
  - enc_datain = payload.
  - At the clock edge: inflight_v<=1, inflight_id<=winner.
- Illegal payload (>= `FTF42_CARD):
  - Word is still accepted (handshake completes) but dropped.
  - enc_datain=0, inflight_v<=0, err_range<=1.
- No grant: enc_datain=0, inflight_v<=0.
- Capture: in the cycle where inflight_v=1, push {inflight_id, enc_codeout} into the FIFO at the edge.
- Latency: acceptance in cycle T -> out_valid in cycle T+2 at the earliest.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Output: FIFO head drives out_code/out_id; pop when out_valid & out_ready.
- Simultaneous push and pop: fifo_count unchanged, including when the FIFO is full.
- Overflow: impossible by credit. Add an assertion that the FIFO is never pushed while full.
- Pointers: FIFO rd/wr pointers wrap modulo FIFO_DEPTH; fifo_count is ID-independent.
- en deasserted mid-stream: no new grants. An in-flight word is still captured and the FIFO drains normally.
- err_clr: err_clr=1 clears err_range. If err_clr and a new illegal payload coincide in the same cycle, the set wins (err_range=1).
- Reset mid-operation: everything above is cleared immediately. The encoder's unreset codeout register is ignored because inflight_v=0.
- Output hold: out_code and out_id are stable while out_valid=1 & out_ready=0.

Decomposition:
- Shared header FNS.vh:
  - existing `FBLEN42 and `FNSxx macros;
  - add `FTF42_CARD (number of legal 42-bit FTF codewords);
  - add `FTF_ID_W default.
- Sub-module ftf_sync_fifo:
  - parameterised WIDTH/DEPTH;
  - async active-low reset;
  - push/pop/full/empty/count.
- Instantiation: the scheduler instantiates ftf_sync_fifo; FTF_encoder_42 stays external, so the top level connects enc_datain/enc_codeout.

Test Plan:
1. Reset then single request: req_valid=0001, data=5, out_ready=1 -> req_ready=0001 in T; out_valid in T+2; out_code = encoder(5); out_id=0.
2. All four requesters valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1...; one out_valid per cycle from T+2; out_id sequence matches the grant order.
3. out_ready=0 with all requesters valid -> exactly 4 grants, then req_ready=0. Raise out_ready -> 4 words out in order, then grants resume.
4. Requester 2 sends `FTF42_CARD, others idle -> req_ready[2]=1; no out_valid; err_range=1 from the next cycle; err_clr pulse -> err_range=0.
5. rst_n pulsed low while 2 words are queued and 1 is in flight -> out_valid=0 immediately; after release, the first new grant goes to requester 0 and no stale word appears.
6. en=0 with a word in flight -> no new req_ready; the in-flight word is still delivered with the correct id.
